multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle variant of the RV32I core. The datapath is split into fetch, decode, execute, memory and writeback steps that share one ALU and one unified memory port. The block decodes the latched instruction fields and sequences the datapath select and enable lines one step per clock. It also flags illegal encodings.

Parameters:
RESET_STATE, 4'd0 (FETCH), encoding of the state entered on reset
TRAP_STICKY, 1, 1 = TRAP is held until reset; 0 = TRAP returns to FETCH after one cycle

Ports:
clk  in  1  core clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
op  in  7  Instr[6:0] from the instruction register
funct3  in  3  Instr[14:12]
funct7b5  in  1  Instr[30]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete (used only under MEM_WAIT_EN)
PCWrite  out  1  PC register load enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction register / OldPC load enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  result select: 00 = ALUOut, 01 = MemData, 10 = ALUResult
ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1
ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = 4
ALUControl  out  4  ALU operation code (see Behaviour)
ImmSrc  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
AddressingControl  out  3  memory access width/sign; equals funct3 in memory states, else 000
instr_done  out  1  one-cycle pulse in the last cycle of each instruction
trap  out  1  high while in TRAP

Behaviour:
- While rst = 0: state = FETCH and every output is forced to 0.
- Outputs are Moore-decoded from the state, except:
  - PCWrite in BRANCH, which depends on Zero;
  - the mem_ready gating described under Optional Feature.
- Any output not listed for a state is 0.
- ALUControl codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 PASSB.
- States, their outputs, and transitions:
  - FETCH: AdrSrc = 0, IRWrite = 1, ALUSrcA = 00, ALUSrcB = 10, ADD, ResultSrc = 10, PCWrite = 1. Next: DECODE.
  - DECODE: ALUSrcA = 01, ALUSrcB = 01, ADD. ImmSrc = 011 if op = 1101111, else 010. Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - anything else -> TRAP
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01, ADD. ImmSrc = 000 for a load, 001 for a store. Next: MEMREAD for a load, MEMWRITE for a store.
  - MEMREAD: AdrSrc = 1. Next: MEMWB.
  - MEMWB: ResultSrc = 01, RegWrite = 1, instr_done = 1. Next: FETCH.
  - MEMWRITE: AdrSrc = 1, MemWrite = 1, instr_done = 1. Next: FETCH.
  - EXEC_R: ALUSrcA = 10, ALUSrcB = 00. ALUControl from funct3:
    - 000: SUB if funct7b5 = 1, else ADD
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
    - 101: SRA if funct7b5 = 1, else SRL
    - 110 OR, 111 AND
    - Next: ALUWB.
  - EXEC_I: ALUSrcA = 10, ALUSrcB = 01, ImmSrc = 000. Same funct3 map as EXEC_R, except 000 is always ADD. Next: ALUWB.
  - ALUWB: ResultSrc = 00, RegWrite = 1, instr_done = 1. Next: FETCH.
  - BRANCH: ALUSrcA = 10, ALUSrcB = 00, ResultSrc = 00 (ALUOut holds the target).
    - Operation and taken condition by funct3: 000 SUB, taken if Zero; 001 SUB, taken if !Zero; 100 SLT, taken if !Zero; 101 SLT, taken if Zero; 110 SLTU, taken if !Zero; 111 SLTU, taken if Zero.
    - PCWrite = taken. instr_done = 1. Next: FETCH.
    - funct3 of 010 or 011: no PCWrite, no instr_done; next state is TRAP.
  - JAL: ALUSrcA = 01, ALUSrcB = 10, ADD, ResultSrc = 00, PCWrite = 1. Next: ALUWB.
  - JALR: ALUSrcA = 10, ALUSrcB = 01, ImmSrc = 000, ADD. Next: JALR_PC.
  - JALR_PC: ALUSrcA = 01, ALUSrcB = 10, ADD, ResultSrc = 00, PCWrite = 1. Next: ALUWB.
  - LUI: ALUSrcB = 01, ImmSrc = 100, PASSB. Next: ALUWB.
  - AUIPC: ALUSrcA = 01, ALUSrcB = 01, ImmSrc = 100, ADD. Next: ALUWB.
  - TRAP: trap = 1; all enables are 0. Stays in TRAP until reset if TRAP_STICKY = 1; otherwise returns to FETCH after one cycle.
- Instruction latency, in cycles: load 5, store 4, R/I/LUI/AUIPC 4, JAL 4, JALR 5, branch 3.
- Async reset asserted mid-instruction: all outputs go to 0 immediately, with no partial write, and the instruction is abandoned.

Optional Feature:
Macro: MEM_WAIT_EN
- Defined:
  - FETCH, MEMREAD and MEMWRITE hold their state while mem_ready = 0.
  - IRWrite and PCWrite (FETCH) and MemWrite (MEMWRITE) are asserted only in the cycle where mem_ready = 1. The address selects stay stable throughout the wait.
  - MEMWRITE's instr_done pulses only in the cycle where mem_ready = 1.
- Not defined: mem_ready is ignored and every state lasts one cycle.

Test Plan:
- Reset, then release rst. In cycle 1: FETCH with PCWrite = 1, IRWrite = 1, ALUSrcB = 10. While rst = 0, all outputs are 0.
- add then sub: op = 0110011, funct3 = 000, funct7b5 = 0, then 1. Sequence FETCH, DECODE, EXEC_R, ALUWB; ALUControl = 0000, then 0001; RegWrite = 1 in cycle 4 only.
- lw: op = 0000011, funct3 = 010. Sequence of 5 states; MEMREAD has AdrSrc = 1 and AddressingControl = 010; MEMWB has ResultSrc = 01. sw: MemWrite = 1 in cycle 4 only.
- beq with Zero = 1: PCWrite = 1 in cycle 3. bne with Zero = 1: PCWrite = 0. Both return to FETCH.
- Illegal op = 1111111: trap = 1 from cycle 3 and held for at least 20 cycles (TRAP_STICKY = 1). Branch with funct3 = 010 also enters TRAP.
- MEM_WAIT_EN defined, mem_ready held at 0 for 3 cycles during FETCH: state stays FETCH, IRWrite = 0 and PCWrite = 0 until mem_ready = 1, then IRWrite = 1 and PCWrite = 1 for exactly one cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback one step per clock,
// driving the shared-ALU and unified-memory selects, and flags illegal ops.
// Optional build macro: MEM_WAIT_EN (FETCH/MEMREAD/MEMWRITE stall on mem_ready).
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter bit         TRAP_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic [2:0] AddressingControl,
    output logic       instr_done,
    output logic       trap
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I,
        ALUWB, BRANCH, JAL, JALR, JALR_PC, LUI, AUIPC, TRAP
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                           ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLT = 4'd5,
                           ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8,
                           ALU_SRA = 4'd9, ALU_PASSB = 4'd10;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                           OP_R = 7'b0110011, OP_I = 7'b0010011,
                           OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111;

    state_t state, nstate;
    logic   rdy;

`ifdef MEM_WAIT_EN
    assign rdy = mem_ready;
`else
    // Memory always completes in one cycle; mem_ready is intentionally unused.
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign rdy = 1'b1;
`endif

    // funct3 -> ALU op for R/I arithmetic; alt selects SUB/SRA.
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_dec = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= state_t'(RESET_STATE);
        else      state <= nstate;
    end

    // Next-state and Moore outputs (BRANCH PCWrite and mem_ready gating aside).
    always_comb begin
        nstate            = state;
        PCWrite           = 1'b0;
        AdrSrc            = 1'b0;
        MemWrite          = 1'b0;
        IRWrite           = 1'b0;
        RegWrite          = 1'b0;
        ResultSrc         = 2'b00;
        ALUSrcA           = 2'b00;
        ALUSrcB           = 2'b00;
        ALUControl        = ALU_ADD;
        ImmSrc            = 3'b000;
        AddressingControl = 3'b000;
        instr_done        = 1'b0;
        trap              = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = rdy;
                PCWrite   = rdy;
                nstate    = rdy ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
                case (op)
                    OP_LOAD, OP_STORE: nstate = MEMADR;
                    OP_R:              nstate = EXEC_R;
                    OP_I:              nstate = EXEC_I;
                    OP_BR:             nstate = BRANCH;
                    OP_JAL:            nstate = JAL;
                    OP_JALR:           nstate = JALR;
                    OP_LUI:            nstate = LUI;
                    OP_AUIPC:          nstate = AUIPC;
                    default:           nstate = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_LOAD) ? 3'b000 : 3'b001;
                nstate  = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc            = 1'b1;
                AddressingControl = funct3;
                nstate            = rdy ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc         = 2'b01;
                RegWrite          = 1'b1;
                AddressingControl = funct3;
                instr_done        = 1'b1;
                nstate            = FETCH;
            end
            MEMWRITE: begin
                AdrSrc            = 1'b1;
                AddressingControl = funct3;
                MemWrite          = rdy;
                instr_done        = rdy;
                nstate            = rdy ? FETCH : MEMWRITE;
            end
            EXEC_R: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec(funct3, funct7b5);
                nstate     = ALUWB;
            end
            EXEC_I: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                // addi has no subtract form; only shifts honour funct7b5.
                ALUControl = alu_dec(funct3, (funct3 != 3'b000) && funct7b5);
                nstate     = ALUWB;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nstate     = FETCH;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                instr_done = 1'b1;
                nstate     = FETCH;
                case (funct3)
                    3'b000: begin ALUControl = ALU_SUB;  PCWrite = Zero;  end
                    3'b001: begin ALUControl = ALU_SUB;  PCWrite = !Zero; end
                    3'b100: begin ALUControl = ALU_SLT;  PCWrite = !Zero; end
                    3'b101: begin ALUControl = ALU_SLT;  PCWrite = Zero;  end
                    3'b110: begin ALUControl = ALU_SLTU; PCWrite = !Zero; end
                    3'b111: begin ALUControl = ALU_SLTU; PCWrite = Zero;  end
                    default: begin
                        ALUControl = ALU_SUB;
                        instr_done = 1'b0;
                        nstate     = TRAP;
                    end
                endcase
            end
            JAL, JALR_PC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                nstate  = ALUWB;
            end
            JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                nstate  = JALR_PC;
            end
            LUI: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 3'b100;
                ALUControl = ALU_PASSB;
                nstate     = ALUWB;
            end
            AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
                nstate  = ALUWB;
            end
            default: begin  // TRAP
                trap   = 1'b1;
                nstate = TRAP_STICKY ? TRAP : FETCH;
            end
        endcase
        // Reset must silence every line at once, not at the next edge.
        if (!rst) begin
            PCWrite           = 1'b0;
            AdrSrc            = 1'b0;
            MemWrite          = 1'b0;
            IRWrite           = 1'b0;
            RegWrite          = 1'b0;
            ResultSrc         = 2'b00;
            ALUSrcA           = 2'b00;
            ALUSrcB           = 2'b00;
            ALUControl        = 4'd0;
            ImmSrc            = 3'b000;
            AddressingControl = 3'b000;
            instr_done        = 1'b0;
            trap              = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven per-cycle vectors plus hand sequences
// for async reset, sticky trap, illegal branch and mem_ready handling.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0] ALUControl;
    logic [2:0] ImmSrc, AddressingControl;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .AddressingControl(AddressingControl), .instr_done(instr_done), .trap(trap)
    );

    always #5 clk = ~clk;

    logic [22:0] outv;
    assign outv = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                   ALUSrcB, ALUControl, ImmSrc, AddressingControl, instr_done, trap};

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [22:0] exp;
    } vec_t;

    vec_t vq[$];
    int   nvec = 0;
    int   nfail = 0;

    function automatic logic [22:0] pk(input logic pcw, adr, mw, irw, rw,
                                       input logic [1:0] rs, sa, sb,
                                       input logic [3:0] alu,
                                       input logic [2:0] imm, ac,
                                       input logic done, tr);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ac, done, tr};
    endfunction

    task automatic chk(input string nm, input logic [22:0] got, input logic [22:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic v(input logic r, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic [22:0] e);
        vec_t t;
        t.rst = r; t.op = o; t.f3 = f3; t.f7 = f7; t.z = z; t.exp = e;
        vq.push_back(t);
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [22:0] Z, F, FW, D, DJ, WB, TR;
        logic [6:0]  R, I, LD, ST, BR, JL, JR, LU, AU;
        Z  = '0;
        F  = pk(1,0,0,1,0,2'b10,2'b00,2'b10,4'd0,3'd0,3'd0,0,0);
        FW = pk(0,0,0,0,0,2'b10,2'b00,2'b10,4'd0,3'd0,3'd0,0,0);
        D  = pk(0,0,0,0,0,2'b00,2'b01,2'b01,4'd0,3'b010,3'd0,0,0);
        DJ = pk(0,0,0,0,0,2'b00,2'b01,2'b01,4'd0,3'b011,3'd0,0,0);
        WB = pk(0,0,0,0,1,2'b00,2'b00,2'b00,4'd0,3'd0,3'd0,1,0);
        TR = pk(0,0,0,0,0,2'b00,2'b00,2'b00,4'd0,3'd0,3'd0,0,1);
        R = 7'b0110011; I = 7'b0010011; LD = 7'b0000011; ST = 7'b0100011;
        BR = 7'b1100011; JL = 7'b1101111; JR = 7'b1100111; LU = 7'b0110111;
        AU = 7'b0010111;

        // reset held, then add / sub
        v(0, R, 3'b000, 0, 0, Z);
        v(0, R, 3'b000, 0, 0, Z);
        v(1, R, 3'b000, 0, 0, F);
        v(1, R, 3'b000, 0, 0, D);
        v(1, R, 3'b000, 0, 0, pk(0,0,0,0,0,2'b00,2'b10,2'b00,4'd0,3'd0,3'd0,0,0));
        v(1, R, 3'b000, 0, 0, WB);
        v(1, R, 3'b000, 1, 0, F);
        v(1, R, 3'b000, 1, 0, D);
        v(1, R, 3'b000, 1, 0, pk(0,0,0,0,0,2'b00,2'b10,2'b00,4'd1,3'd0,3'd0,0,0));
        v(1, R, 3'b000, 1, 0, WB);
        // lw
        v(1, LD, 3'b010, 0, 0, F);
        v(1, LD, 3'b010, 0, 0, D);
        v(1, LD, 3'b010, 0, 0, pk(0,0,0,0,0,2'b00,2'b10,2'b01,4'd0,3'b000,3'd0,0,0));
        v(1, LD, 3'b010, 0, 0, pk(0,1,0,0,0,2'b00,2'b00,2'b00,4'd0,3'd0,3'b010,0,0));
        v(1, LD, 3'b010, 0, 0, pk(0,0,0,0,1,2'b01,2'b00,2'b00,4'd0,3'd0,3'b010,1,0));
        // sw
        v(1, ST, 3'b010, 0, 0, F);
        v(1, ST, 3'b010, 0, 0, D);
        v(1, ST, 3'b010, 0, 0, pk(0,0,0,0,0,2'b00,2'b10,2'b01,4'd0,3'b001,3'd0,0,0));
        v(1, ST, 3'b010, 0, 0, pk(0,1,1,0,0,2'b00,2'b00,2'b00,4'd0,3'd0,3'b010,1,0));
        // beq Zero=1 (taken), bne Zero=1 (not taken), blt Zero=0 (taken), bgeu Zero=0 (not taken)
        v(1, BR, 3'b000, 0, 1, F);
        v(1, BR, 3'b000, 0, 1, D);
        v(1, BR, 3'b000, 0, 1, pk(1,0,0,0,0,2'b00,2'b10,2'b00,4'd1,3'd0,3'd0,1,0));
        v(1, BR, 3'b001, 0, 1, F);
        v(1, BR, 3'b001, 0, 1, D);
        v(1, BR, 3'b001, 0, 1, pk(0,0,0,0,0,2'b00,2'b10,2'b00,4'd1,3'd0,3'd0,1,0));
        v(1, BR, 3'b100, 0, 0, F);
        v(1, BR, 3'b100, 0, 0, D);
        v(1, BR, 3'b100, 0, 0, pk(1,0,0,0,0,2'b00,2'b10,2'b00,4'd5,3'd0,3'd0,1,0));
        v(1, BR, 3'b111, 0, 0, F);
        v(1, BR, 3'b111, 0, 0, D);
        v(1, BR, 3'b111, 0, 0, pk(0,0,0,0,0,2'b00,2'b10,2'b00,4'd6,3'd0,3'd0,1,0));
        // jal
        v(1, JL, 3'b000, 0, 0, F);
        v(1, JL, 3'b000, 0, 0, DJ);
        v(1, JL, 3'b000, 0, 0, pk(1,0,0,0,0,2'b00,2'b01,2'b10,4'd0,3'd0,3'd0,0,0));
        v(1, JL, 3'b000, 0, 0, WB);
        // addi with funct7b5 set stays ADD; srai gives SRA
        v(1, I, 3'b000, 1, 0, F);
        v(1, I, 3'b000, 1, 0, D);
        v(1, I, 3'b000, 1, 0, pk(0,0,0,0,0,2'b00,2'b10,2'b01,4'd0,3'b000,3'd0,0,0));
        v(1, I, 3'b000, 1, 0, WB);
        v(1, I, 3'b101, 1, 0, F);
        v(1, I, 3'b101, 1, 0, D);
        v(1, I, 3'b101, 1, 0, pk(0,0,0,0,0,2'b00,2'b10,2'b01,4'd9,3'b000,3'd0,0,0));
        v(1, I, 3'b101, 1, 0, WB);
        // jalr (5 cycles)
        v(1, JR, 3'b000, 0, 0, F);
        v(1, JR, 3'b000, 0, 0, D);
        v(1, JR, 3'b000, 0, 0, pk(0,0,0,0,0,2'b00,2'b10,2'b01,4'd0,3'b000,3'd0,0,0));
        v(1, JR, 3'b000, 0, 0, pk(1,0,0,0,0,2'b00,2'b01,2'b10,4'd0,3'd0,3'd0,0,0));
        v(1, JR, 3'b000, 0, 0, WB);
        // lui, auipc
        v(1, LU, 3'b000, 0, 0, F);
        v(1, LU, 3'b000, 0, 0, D);
        v(1, LU, 3'b000, 0, 0, pk(0,0,0,0,0,2'b00,2'b00,2'b01,4'd10,3'b100,3'd0,0,0));
        v(1, LU, 3'b000, 0, 0, WB);
        v(1, AU, 3'b000, 0, 0, F);
        v(1, AU, 3'b000, 0, 0, D);
        v(1, AU, 3'b000, 0, 0, pk(0,0,0,0,0,2'b00,2'b01,2'b01,4'd0,3'b100,3'd0,0,0));
        v(1, AU, 3'b000, 0, 0, WB);

        mem_ready = 1'b1;
        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; op = vq[i].op; funct3 = vq[i].f3;
            funct7b5 = vq[i].f7; Zero = vq[i].z;
            #1 chk($sformatf("vec%0d", i), outv, vq[i].exp);
        end

        // Async reset in MEMREAD: outputs drop before any clock edge.
        op = LD; funct3 = 3'b010; funct7b5 = 0; Zero = 0;
        @(negedge clk); #1 chk("lw2_fetch", outv, F);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1 chk("lw2_memread", outv, pk(0,1,0,0,0,2'b00,2'b00,2'b00,4'd0,3'd0,3'b010,0,0));
        #1 rst = 0;
        #1 chk("async_rst_now", outv, Z);
        @(negedge clk); #1 chk("async_rst_held", outv, Z);
        rst = 1;
        #1 chk("after_rst_fetch", outv, F);

        // Illegal opcode: trap from cycle 3, sticky.
        op = 7'b1111111;
        @(negedge clk); #1 chk("illegal_decode", outv, D);
        for (int k = 0; k < 21; k++) begin
            @(negedge clk); #1 chk($sformatf("trap_hold%0d", k), outv, TR);
        end
        rst = 0;
        @(negedge clk); rst = 1;
        #1 chk("trap_cleared", outv, F);

        // Branch with funct3=010 goes to TRAP without PCWrite/instr_done.
        op = BR; funct3 = 3'b010; Zero = 1;
        @(negedge clk);
        @(negedge clk); #1 chk("br010_pcw_done", {21'd0, PCWrite, instr_done}, 23'd0);
        @(negedge clk); #1 chk("br010_trap", outv, TR);
        rst = 0;
        @(negedge clk); rst = 1; Zero = 0;

`ifdef MEM_WAIT_EN
        // FETCH stalls while mem_ready is low, then loads exactly once.
        op = R; funct3 = 3'b000; funct7b5 = 0; mem_ready = 0;
        #1 chk("wait_fetch0", outv, FW);
        @(negedge clk); #1 chk("wait_fetch1", outv, FW);
        @(negedge clk); #1 chk("wait_fetch2", outv, FW);
        @(negedge clk); mem_ready = 1;
        #1 chk("wait_fetch_go", outv, F);
        @(negedge clk); #1 chk("wait_decode", outv, D);
`else
        // mem_ready is ignored: an add still completes in 4 cycles.
        op = R; funct3 = 3'b000; funct7b5 = 0; mem_ready = 0;
        #1 chk("nowait_fetch", outv, F);
        @(negedge clk); #1 chk("nowait_decode", outv, D);
        @(negedge clk); #1 chk("nowait_exec", outv, pk(0,0,0,0,0,2'b00,2'b10,2'b00,4'd0,3'd0,3'd0,0,0));
        @(negedge clk); #1 chk("nowait_wb", outv, WB);
        @(negedge clk); #1 chk("nowait_refetch", outv, F);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
